// File: rtl/mem_access_unit.sv
// Load/store responder: runs lb/lw/sb/sw on a word-wide req/ack data-memory bus.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned word accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            memory_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  err,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lane_q;
  logic             byte_q;
  logic             valid_op_c;
  logic             word_c;
  logic             accept_c;
  logic             timeout_c;
  logic [7:0]       lane_byte_c;

  assign word_c     = (memory_mode == 3'd2);
  assign valid_op_c = req_valid & (load ^ store) & ((memory_mode == 3'd1) | word_c);

`ifdef MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = valid_op_c & word_c & (addr[1:0] != 2'b00);
  assign accept_c   = valid_op_c & ~misalign_c;
`else
  assign accept_c   = valid_op_c;
`endif

  // Counter reaching TIMEOUT_CYCLES at this edge ends the request.
  assign timeout_c = (TIMEOUT_CYCLES != 0) &&
                     (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(TIMEOUT_CYCLES));

  assign lane_byte_c = mem_rdata[{lane_q, 3'b000} +: 8];

  assign busy = ~rst & ((state_q == ST_REQ) | ((state_q == ST_IDLE) & accept_c));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack)        state_d = ST_RESP;
        else if (timeout_c) state_d = ST_IDLE;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lane_q    <= 2'b00;
      byte_q    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            mem_req   <= 1'b1;
            mem_we    <= store;
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= (store & ~word_c) ? 4'(4'b0001 << addr[1:0]) : 4'hF;
            mem_wdata <= word_c ? wdata : {4{wdata[7:0]}};
            lane_q    <= addr[1:0];
            byte_q    <= ~word_c;
            cnt_q     <= '0;
          end
`ifdef MISALIGN_TRAP_EN
          misalign <= misalign_c;
`endif
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= byte_q ? {{24{lane_byte_c[7]}}, lane_byte_c} : mem_rdata;
          end else if (timeout_c) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
